// File: rtl/upscaler_pkg.sv
// Shared types and constants for the upscaler output path.
package upscaler_pkg;

  localparam int PIXEL_W        = 24;
  localparam int DEF_CELL_SIZE  = 2;
  localparam int DEF_CHUNK_SIZE = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_raster_counter.sv
// Nested col -> cell -> row counters that walk a chunk in raster order.
module chunk_raster_counter
  import upscaler_pkg::*;
#(
  parameter int CELL_SIZE  = DEF_CELL_SIZE,
  parameter int CHUNK_SIZE = DEF_CHUNK_SIZE,
  localparam int COL_W     = cnt_w(CELL_SIZE),
  localparam int CELL_W    = cnt_w(CHUNK_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [COL_W-1:0]  col_o,
  output logic [CELL_W-1:0] cell_o,
  output logic [COL_W-1:0]  row_o,
  output logic              eol_o,
  output logic              eoc_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  logic [COL_W-1:0]  row_q, row_d;
  logic              col_last, cell_last, row_last;

  assign col_last  = (col_q == COL_W'(CELL_SIZE - 1));
  assign cell_last = (cell_q == CELL_W'(CHUNK_SIZE - 1));
  assign row_last  = (row_q == COL_W'(CELL_SIZE - 1));

  // Clear wins over advance so a freshly loaded chunk always starts at [0][0][0].
  always_comb begin
    col_d  = col_q;
    cell_d = cell_q;
    row_d  = row_q;
    if (clear_i) begin
      col_d  = '0;
      cell_d = '0;
      row_d  = '0;
    end else if (advance_i) begin
      if (col_last) begin
        col_d = '0;
        if (cell_last) begin
          cell_d = '0;
          row_d  = row_last ? '0 : row_q + 1'b1;
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      cell_q <= '0;
      row_q  <= '0;
    end else begin
      col_q  <= col_d;
      cell_q <= cell_d;
      row_q  <= row_d;
    end
  end

  assign col_o  = col_q;
  assign cell_o = cell_q;
  assign row_o  = row_q;
  assign eol_o  = col_last & cell_last;
  assign eoc_o  = col_last & cell_last & row_last;

endmodule

// File: rtl/chunk_serializer.sv
// Turns one cell-major chunk into a raster-order pixel stream.
// Optional double buffering of the next chunk: CHUNK_SERIALIZER_DBUF_EN.
module chunk_serializer
  import upscaler_pkg::*;
#(
  parameter int CELL_SIZE  = DEF_CELL_SIZE,
  parameter int CHUNK_SIZE = DEF_CHUNK_SIZE,
  localparam int COL_W     = cnt_w(CELL_SIZE),
  localparam int CELL_W    = cnt_w(CHUNK_SIZE)
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  pixel_t [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] in_chunk,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  output logic [PIXEL_W-1:0]                                   out_pixel,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic                                                 out_eol,
  output logic                                                 out_eoc
);

  // Both sides use valid/ready: a beat moves on a rising edge where valid and
  // ready are both high; valid never waits for ready, and once raised the
  // offered beat holds until taken. in_ready is a register, so the input side
  // never sees out_ready combinationally.

  state_t state_q;
  logic   in_ready_q;
  logic   out_valid_q;
  pixel_t [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] chunk_q;

  logic              in_xfer, out_xfer, last_xfer, cnt_clear;
  logic [COL_W-1:0]  col_cnt, row_cnt;
  logic [CELL_W-1:0] cell_cnt;
  logic              cnt_eol, cnt_eoc;

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid_q & out_ready;
  assign last_xfer = out_xfer & cnt_eoc;

`ifdef CHUNK_SERIALIZER_DBUF_EN
  pixel_t [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] pend_q;
  logic pend_full_q;

  assign cnt_clear = ((state_q == IDLE) & in_xfer) |
                     (last_xfer & (pend_full_q | in_xfer));
`else
  assign cnt_clear = (state_q == IDLE) & in_xfer;
`endif

  chunk_raster_counter #(
    .CELL_SIZE (CELL_SIZE),
    .CHUNK_SIZE(CHUNK_SIZE)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .advance_i(out_xfer),
    .col_o    (col_cnt),
    .cell_o   (cell_cnt),
    .row_o    (row_cnt),
    .eol_o    (cnt_eol),
    .eoc_o    (cnt_eoc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      chunk_q     <= '0;
`ifdef CHUNK_SERIALIZER_DBUF_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            chunk_q     <= in_chunk;
            state_q     <= STREAM;
            out_valid_q <= 1'b1;
`ifndef CHUNK_SERIALIZER_DBUF_EN
            in_ready_q  <= 1'b0;
`endif
          end
        end
        STREAM: begin
          if (last_xfer) begin
`ifdef CHUNK_SERIALIZER_DBUF_EN
            if (pend_full_q) begin
              chunk_q     <= pend_q;
              pend_full_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else if (in_xfer) begin
              // Chunk arrived exactly on the last pixel: bypass the pending slot.
              chunk_q <= in_chunk;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
`else
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`endif
          end
`ifdef CHUNK_SERIALIZER_DBUF_EN
          else if (in_xfer) begin
            pend_q      <= in_chunk;
            pend_full_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_valid_q ? chunk_q[cell_cnt][row_cnt][col_cnt] : '0;
  assign out_eol   = out_valid_q & cnt_eol;
  assign out_eoc   = out_valid_q & cnt_eoc;

endmodule

// File: tb/tb_chunk_serializer.sv
// Self-checking bench for chunk_serializer (2x3 main instance, 1x1 degenerate instance).
module tb_chunk_serializer;

  localparam int CS  = 2;
  localparam int CH  = 3;
  localparam int N   = CS * CS * CH;
  localparam int CW  = N * 24;
`ifdef CHUNK_SERIALIZER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [CW-1:0] in_chunk;
  logic          in_valid, in_ready;
  logic [23:0]   out_pixel;
  logic          out_valid, out_ready, out_eol, out_eoc;

  logic [23:0]   in_chunk1;
  logic          in_valid1, in_ready1;
  logic [23:0]   out_pixel1;
  logic          out_valid1, out_ready1, out_eol1, out_eoc1;

  int errors = 0;
  int checks = 0;

  logic [25:0]   exp_q[$];
  logic [CW-1:0] chunks[4];

  chunk_serializer #(.CELL_SIZE(CS), .CHUNK_SIZE(CH)) dut (
    .clk(clk), .reset(reset), .in_chunk(in_chunk), .in_valid(in_valid),
    .in_ready(in_ready), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_eol(out_eol), .out_eoc(out_eoc)
  );

  chunk_serializer #(.CELL_SIZE(1), .CHUNK_SIZE(1)) dut1 (
    .clk(clk), .reset(reset), .in_chunk(in_chunk1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_pixel(out_pixel1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_eol(out_eol1), .out_eoc(out_eoc1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] pattern_chunk();
    logic [CW-1:0] ch;
    ch = '0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < CS; r++)
        for (int k = 0; k < CS; k++)
          ch[((c * CS + r) * CS + k) * 24 +: 24] = 24'((c << 8) | (r << 4) | k);
    return ch;
  endfunction

  function automatic logic [CW-1:0] rand_chunk();
    logic [CW-1:0] ch;
    for (int i = 0; i < N; i++) ch[i * 24 +: 24] = 24'($urandom);
    return ch;
  endfunction

  // Reference model: raster order is row-major over the whole chunk width.
  task automatic push_chunk(input logic [CW-1:0] ch);
    logic eol, eoc;
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < CS; k++) begin
          eol = (k == CS - 1) && (c == CH - 1);
          eoc = eol && (r == CS - 1);
          exp_q.push_back({eoc, eol, ch[((c * CS + r) * CS + k) * 24 +: 24]});
        end
  endtask

  function automatic logic ready_bit(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Driver + scoreboard: offers chunks[0..nch-1] with in_valid held high.
  task automatic run_stream(input int nch, input int mode, output int bubbles);
    int  sent, popped, started, cyc;
    bit  mid, in_fire, out_fire, was_idle;
    logic [25:0] got;
    sent = 0; popped = 0; bubbles = 0; mid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < nch; i++) push_chunk(chunks[i]);
    in_valid = 1'b1;
    in_chunk = chunks[0];
    for (cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
      out_ready = ready_bit(mode, cyc);
      if (out_valid) begin
        chk("pixel_flags", 32'({out_eoc, out_eol, out_pixel}), 32'(exp_q[0]));
        mid = 1'b0;
        started = popped / N + 1;
        chk("in_ready_busy", 32'(in_ready), DBUF ? 32'(sent == started) : 32'd0);
      end else begin
        if (mid) bubbles++;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      was_idle = !out_valid;
      tick();
      if (out_fire) begin
        got = exp_q.pop_front();
        popped++;
        if (got[25] && exp_q.size() > 0) mid = 1'b1;
      end
      if (in_fire) begin
        sent++;
        if (was_idle) chk("first_pixel_latency", 32'(out_valid), 32'd1);
        if (sent < nch) in_chunk = chunks[sent];
        else begin
          in_valid = 1'b0;
          in_chunk = rand_chunk();
        end
      end
    end
    in_valid = 1'b0;
    chk("stream_done_in_budget", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int b;
    reset = 1'b1; in_valid = 1'b0; in_chunk = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_chunk1 = '0; out_ready1 = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_eol_eoc", 32'({out_eol, out_eoc}), 32'd0);
    reset = 1'b0;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // Directed cell/row/col nibble pattern, no back-pressure.
    chunks[0] = pattern_chunk();
    run_stream(1, 0, b);
    tick();

    // Same chunk under 1,0,0,1 back-pressure.
    run_stream(1, 1, b);
    tick();

    // Two chunks back-to-back with in_valid held high.
    chunks[0] = pattern_chunk();
    chunks[1] = rand_chunk();
    run_stream(2, 0, b);
    chk("b2b_bubbles", 32'(b), DBUF ? 32'd0 : 32'd1);
    tick();

    // Random data and random back-pressure.
    for (int i = 0; i < 3; i++) chunks[i] = rand_chunk();
    run_stream(3, 2, b);
    chk("rand_bubbles", 32'(b), DBUF ? 32'd0 : 32'd2);
    tick();

    // Reset after the 5th pixel transfer.
    exp_q.delete();
    push_chunk(pattern_chunk());
    chk("pre_rst_in_ready", 32'(in_ready), 32'd1);
    in_chunk = pattern_chunk(); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_pixel", 32'({out_eoc, out_eol, out_pixel}), 32'(exp_q.pop_front()));
      tick();
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_pixel_flags", 32'({out_eoc, out_eol, out_pixel}), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_in_ready_rise", 32'(in_ready), 32'd1);
    chk("mid_rst_idle", 32'(out_valid), 32'd0);
    chunks[0] = pattern_chunk();
    run_stream(1, 0, b);
    tick();

    // Degenerate 1x1 instance.
    chk("d1_in_ready", 32'(in_ready1), 32'd1);
    in_chunk1 = 24'hABCDEF; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0; in_chunk1 = 24'($urandom);
    chk("d1_out_valid", 32'(out_valid1), 32'd1);
    chk("d1_pixel", 32'(out_pixel1), 32'hABCDEF);
    chk("d1_eol_eoc", 32'({out_eol1, out_eoc1}), 32'd3);
    tick();
    chk("d1_back_idle", 32'(out_valid1), 32'd0);
    chk("d1_in_ready_again", 32'(in_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
